// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the pc through instruction memory, buffers one
// word for decode, and redirects with a drain/flush window on taken jumps.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        flush
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [3:0]  flush_cnt;
    logic [31:0] jump_pc;
    logic        consumed;
    logic        req_pending;

    assign jump_pc     = jump_target & 32'hFFFF_FFFC;
    assign consumed    = inst_valid && !stall;
    assign req_pending = imem_req && !imem_ack;
    assign flush       = (state == DRAIN) || (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            imem_req   <= '0;
            imem_addr  <= '0;
            inst_valid <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            flush_cnt  <= '0;
        end else if (jump_flag) begin
            pc         <= jump_pc;
            inst_valid <= 1'b0;
            flush_cnt  <= FLUSH_LOAD;
            // An unacknowledged request stays on the bus until memory answers it.
            if (req_pending) begin
                state <= DRAIN;
            end else begin
                state    <= FLUSH;
                imem_req <= 1'b0;
            end
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                            imem_req   <= 1'b0;
                        end else if (consumed) begin
                            inst_valid <= 1'b0;
                        end
                    end else if (!inst_valid || consumed) begin
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                        inst_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) state <= FETCH;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed timing scenarios plus a randomized run checked
// against address/instruction stream rules derived from pc arithmetic and jump targets.
module tb_fetch_sequencer;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2 = 1'b0;
    logic [31:0] imem_rdata2 = '0;
    logic        inst_valid2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic        flush2;
    logic        jump_flag2 = 1'b0;
    logic [31:0] jump_target2 = '0;
    logic        stall2 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    int ack_delay = 1;
    int wait_cnt  = 0;
    bit rand_lat  = 1'b0;
    bit force_ack = 1'b0;
    logic [31:0] q2[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag), .jump_target(jump_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .flush(flush)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .FLUSH_CYCLES(FC)) dut2 (
        .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag2), .jump_target(jump_target2),
        .stall(stall2), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
        .imem_rdata(imem_rdata2), .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .flush(flush2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: ack after ack_delay cycles of an asserted request, junk data otherwise.
    always @(negedge clk) begin
        if (imem_req && rst_n) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = word(imem_addr);
                wait_cnt   = 0;
                if (rand_lat) ack_delay = int'($urandom_range(0, 3));
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            imem_ack   = force_ack;
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
    end

    always @(negedge clk) begin
        imem_ack2   = imem_req2 && rst_n;
        imem_rdata2 = word(imem_addr2);
    end

    always @(negedge clk) begin
        #3;
        if (!rst_n) q2.delete();
        else if (imem_req2 && imem_ack2) q2.push_back(imem_addr2);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic park();
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        stall = 1'b1; jump_flag = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!ok) begin
                #3;
                if (inst_valid && !imem_req && !flush) ok = 1'b1;
                else @(negedge clk);
            end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL park_timeout: got no parked buffer, want inst_valid=1 within 40 cycles"); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; jump_flag = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
        @(negedge clk); rst_n = 1'b1; #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b want 0", imem_req); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fetch_idle_req: got %b want 0", imem_req); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit found;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            found = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (!found && imem_req && imem_ack) found = 1'b1;
                if (!found) begin @(negedge clk); #3; end
            end
            n_cmp++; if (!found) begin n_err++; $display("FAIL seq_ack_timeout: got no ack, want ack for %h", a); end
            n_cmp++; if (imem_addr !== a) begin n_err++; $display("FAIL seq_addr: got %h want %h", imem_addr, a); end
            @(negedge clk);
            if (i == 2) stall = 1'b1;
            #3;
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid: got %b want 1", inst_valid); end
            n_cmp++; if (inst_pc !== a) begin n_err++; $display("FAIL seq_inst_pc: got %h want %h", inst_pc, a); end
            n_cmp++; if (inst !== word(a)) begin n_err++; $display("FAIL seq_inst: got %h want %h", inst, word(a)); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_gap_req: got %b want 0", imem_req); end
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #3;
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", inst_valid); end
            n_cmp++; if (inst_pc !== 32'h8) begin n_err++; $display("FAIL stall_inst_pc: got %h want 8", inst_pc); end
            n_cmp++; if (inst !== word(32'h8)) begin n_err++; $display("FAIL stall_inst: got %h want %h", inst, word(32'h8)); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", imem_req); end
        end
        @(negedge clk); stall = 1'b0; #3;
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL unstall_valid: got %b want 1", inst_valid); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL unstall_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'hC) begin n_err++; $display("FAIL unstall_addr: got %h want c", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL unstall_cleared: got %b want 0", inst_valid); end
    endtask

    task automatic test_jump_idle();
        park();
        @(negedge clk); jump_flag = 1'b1; jump_target = 32'h103; #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL jidle_no_req: got %b want 0", imem_req); end
        @(negedge clk); jump_flag = 1'b0; stall = 1'b0; #3;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jidle_flush1: got %b want 1", flush); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL jidle_valid: got %b want 0", inst_valid); end
        @(negedge clk); #3;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jidle_flush2: got %b want 1", flush); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL jidle_flush_req: got %b want 0", imem_req); end
        @(negedge clk); #3;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL jidle_flush_end: got %b want 0", flush); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL jidle_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL jidle_addr: got %h want 100", imem_addr); end
    endtask

    task automatic test_jump_drain();
        bit found;
        park();
        @(negedge clk); jump_flag = 1'b1; jump_target = 32'h10; #3;
        @(negedge clk); jump_flag = 1'b0; stall = 1'b0; ack_delay = 3; #3;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!found && imem_req) found = 1'b1;
            if (!found) begin @(negedge clk); #3; end
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL drain_req_timeout: got no req, want req at 10"); end
        n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL drain_first_addr: got %h want 10", imem_addr); end
        @(negedge clk); jump_flag = 1'b1; jump_target = 32'h200; #3;
        n_cmp++; if (imem_ack !== 1'b0) begin n_err++; $display("FAIL drain_pending: got ack %b want 0", imem_ack); end
        @(negedge clk); jump_flag = 1'b0; #3;
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL drain_flush: got %b want 1", flush); end
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL drain_req_held: got %b want 1", imem_req); end
            n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL drain_addr_held: got %h want 10", imem_addr); end
            if (c == 0) begin @(negedge clk); #3; end
        end
        n_cmp++; if (imem_ack !== 1'b1) begin n_err++; $display("FAIL drain_ack_cycle: got %b want 1", imem_ack); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #3;
            n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL drain_post_flush: got %b want 1", flush); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL drain_post_req: got %b want 0", imem_req); end
            n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL drain_discard: got %b want 0", inst_valid); end
        end
        @(negedge clk); ack_delay = 1; #3;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL drain_flush_end: got %b want 0", flush); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL drain_new_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL drain_new_addr: got %h want 200", imem_addr); end
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!found && inst_valid) found = 1'b1;
            if (!found) begin @(negedge clk); #3; end
        end
        n_cmp++; if (inst_pc !== 32'h200) begin n_err++; $display("FAIL drain_inst_pc: got %h want 200", inst_pc); end
        n_cmp++; if (inst !== word(32'h200)) begin n_err++; $display("FAIL drain_inst: got %h want %h", inst, word(32'h200)); end
    endtask

    task automatic test_double_jump();
        park();
        @(negedge clk); jump_flag = 1'b1; jump_target = 32'h300; #3;
        @(negedge clk); jump_flag = 1'b0; stall = 1'b0; #3;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL dj_flush_a: got %b want 1", flush); end
        @(negedge clk); jump_flag = 1'b1; jump_target = 32'h40; #3;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL dj_flush_b: got %b want 1", flush); end
        @(negedge clk); jump_flag = 1'b0; #3;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL dj_reload_1: got %b want 1", flush); end
        @(negedge clk); #3;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL dj_reload_2: got %b want 1", flush); end
        @(negedge clk); #3;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL dj_flush_end: got %b want 0", flush); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL dj_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL dj_addr: got %h want 40", imem_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_cons, exp_fetch, prev_addr;
        logic        prev_req, prev_ack;
        bit          have_prev;
        int          flush_left, consumed_n;
        have_prev = 1'b0; flush_left = 0; consumed_n = 0;
        exp_cons = '0; exp_fetch = '0; prev_addr = '0; prev_req = 1'b0; prev_ack = 1'b0;
        rand_lat = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            jump_flag   = (c == 0) || ($urandom_range(0, 15) == 0);
            jump_target = $urandom;
            stall       = ($urandom_range(0, 2) == 0);
            #3;
            if (have_prev && prev_req && !prev_ack) begin
                n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rnd_hold_req: got %b want 1", imem_req); end
                n_cmp++; if (imem_addr !== prev_addr) begin n_err++; $display("FAIL rnd_hold_addr: got %h want %h", imem_addr, prev_addr); end
            end
            if (have_prev && prev_req && prev_ack) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_ack_gap: got %b want 0", imem_req); end
            end
            if (flush_left > 0) begin
                n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL rnd_flush_window: got %b want 1", flush); end
                flush_left--;
            end
            if (flush) begin
                n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush_valid: got %b want 0", inst_valid); end
            end
            if (!jump_flag && !flush && imem_req && imem_ack) begin
                n_cmp++; if (imem_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_fetch_addr: got %h want %h", imem_addr, exp_fetch); end
                exp_fetch = exp_fetch + 32'd4;
            end
            if (!jump_flag && inst_valid && !stall) begin
                n_cmp++; if (inst_pc !== exp_cons) begin n_err++; $display("FAIL rnd_inst_pc: got %h want %h", inst_pc, exp_cons); end
                n_cmp++; if (inst !== word(exp_cons)) begin n_err++; $display("FAIL rnd_inst: got %h want %h", inst, word(exp_cons)); end
                exp_cons = exp_cons + 32'd4;
                consumed_n++;
            end
            if (jump_flag) begin
                exp_cons   = jump_target & 32'hFFFF_FFFC;
                exp_fetch  = exp_cons;
                flush_left = FC;
            end
            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr; have_prev = 1'b1;
        end
        n_cmp++; if (consumed_n < 100) begin n_err++; $display("FAIL rnd_progress: got %0d consumed want >= 100", consumed_n); end
        @(negedge clk);
        jump_flag = 1'b0; stall = 1'b0; rand_lat = 1'b0; ack_delay = 1;
    endtask

    task automatic test_reset_mid_request();
        bit found;
        found = 1'b0;
        #3;
        for (int c = 0; c < 30; c++) begin
            if (!found && imem_req) found = 1'b1;
            if (!found) begin @(negedge clk); #3; end
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL rmid_req_timeout: got no req, want req within 30 cycles"); end
        rst_n = 1'b0; force_ack = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req_drop: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_addr: got %h want 0", imem_addr); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rmid_flush: got %b want 0", flush); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", inst_valid); end
        @(negedge clk); rst_n = 1'b1; #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_boot_req: got %b want 0", imem_req); end
        @(negedge clk); #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_idle_req: got %b want 0", imem_req); end
        force_ack = 1'b0;
        @(negedge clk); #3;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stray_ack: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_req_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 20; c++) begin
            if (q2.size() < 2) @(negedge clk);
        end
        #4;
        n_cmp++;
        if (q2.size() < 2) begin
            n_err++; $display("FAIL wrap_timeout: got %0d fetches want 2", q2.size());
        end else begin
            if (q2[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first: got %h want fffffffc", q2[0]); end
            n_cmp++; if (q2[1] !== 32'h0) begin n_err++; $display("FAIL wrap_second: got %h want 0", q2[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump_idle();
        test_jump_drain();
        test_double_jump();
        test_random();
        test_reset_mid_request();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..15: number of cycles flush is held after a redirect.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port jump_flag  input  1: taken branch or jump from the jump controller.
REQ-006 SHALL have port jump_target  input  32: redirect address, valid when jump_flag=1.
REQ-007 SHALL have port stall  input  1: decode stage cannot accept an instruction this cycle.
REQ-008 SHALL have port imem_req  output  1: instruction memory request.
REQ-009 SHALL have port imem_addr  output  32: request address.
REQ-010 SHALL have port imem_ack  input  1: request complete; imem_rdata is valid in the same cycle.
REQ-011 SHALL have port imem_rdata  input  32: fetched instruction word.
REQ-012 SHALL have port inst_valid  output  1: inst and inst_pc hold an instruction for decode.
REQ-013 SHALL have port inst  output  32: buffered instruction.
REQ-014 SHALL have port inst_pc  output  32: address of inst.
REQ-015 SHALL have port flush  output  1: decode and execute must kill in-flight instructions.

Function
REQ-016 SHALL implement the states BOOT, FETCH, DRAIN and FLUSH, with a registered pc, a one-entry instruction buffer and a 4-bit flush counter.
REQ-017 SHALL leave BOOT for FETCH unconditionally one cycle after reset release, with imem_req=0 while in BOOT.
REQ-018 SHALL, in FETCH, assert imem_req only when the buffer is empty or is consumed this cycle; consumed means inst_valid=1 and stall=0.
REQ-019 SHALL latch imem_addr=pc in the cycle a request is issued, and hold imem_req and imem_addr stable until the cycle imem_ack=1.
REQ-020 SHALL, on imem_ack in FETCH, set inst=imem_rdata, inst_pc=imem_addr and inst_valid=1, and set pc=pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 SHALL issue the next request in the cycle after an ack, not the same cycle, giving a minimum of 2 cycles per fetch.
REQ-022 SHALL clear inst_valid on consumption unless a new ack loads the buffer in the same cycle.
REQ-023 SHALL hold inst and inst_pc unchanged while inst_valid=1 and stall=1.
REQ-024 SHALL give jump_flag priority over stall, ack and consumption.
REQ-025 SHALL, on jump_flag=1, set pc={jump_target[31:2],2'b00}, clear inst_valid, and load the flush counter with FLUSH_CYCLES.
REQ-026 SHALL, on a jump with a request outstanding (imem_req=1 and no ack in that cycle), enter DRAIN; otherwise it SHALL enter FLUSH.
REQ-027 SHALL, in DRAIN, keep imem_req and imem_addr asserted, discard imem_rdata on ack, and move to FLUSH on ack.
REQ-028 SHALL assert flush=1 in the cycle after a jump and for every cycle in DRAIN and FLUSH.
REQ-029 SHALL, in FLUSH, hold imem_req=0 and decrement the counter each cycle; when the count reaches 1 it SHALL go to FETCH.
REQ-030 SHALL, on a further jump in DRAIN or FLUSH, overwrite pc, reload the counter, and remain in or enter DRAIN according to REQ-026.
REQ-031 SHALL keep inst_valid=0 in BOOT, DRAIN and FLUSH.

Reset
REQ-032 SHALL, on rst_n=0 and regardless of clk, force: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, flush=0, counter=0.
REQ-033 SHALL, on reset asserted mid-request, drop imem_req immediately; an abandoned ack after reset SHALL be ignored.

Verification
REQ-034 SHALL verify: reset release with ack returned 1 cycle after each req and stall=0 -> addresses 0,4,8 fetched; inst_pc follows each word.
REQ-035 SHALL verify: stall=1 for 5 cycles with a buffered word at 0x8 -> inst and inst_pc hold, and no new req while the buffer is full.
REQ-036 SHALL verify: jump_flag=1 with target 0x103 and no request outstanding -> flush=1 for 2 cycles, then req at addr 0x100.
REQ-037 SHALL verify: jump to 0x200 while req at 0x10 awaits ack for 3 cycles -> addr 0x10 held, its data discarded, then FLUSH, then req at 0x200.
REQ-038 SHALL verify: second jump to 0x40 during FLUSH -> counter reloads and the first fetch goes to 0x40.
REQ-039 SHALL verify: RESET_PC=32'hFFFF_FFFC -> the second fetch address is 32'h0000_0000.
